// File: rtl/uart_baud_ctrl.sv
// uart_baud_ctrl
//   Baud-tick controller for the UART. It divides fast_clk by a divisor that
//   can be loaded at runtime and produces two one-cycle strobes: rx_tick, the
//   oversample strobe, and tx_tick, the bit strobe. tx_tick falls on every
//   OVERSAMPLE-th rx_tick.
//   The divisor is loaded through a valid/ready handshake. When a new divisor
//   arrives while the controller is running, it is held back until the current
//   bit finishes, so no bit is ever cut short.
//
//   Optional feature macro: UART_BAUD_FRAC_EN
//     When defined, the block gains a cfg_frac port that sets a fractional
//     divisor in 1/16 steps. A 4-bit phase accumulator lengthens some sample
//     periods by one fast_clk cycle.
//
// Ports
//   fast_clk   in   clock; all logic runs on its rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   1 = generate ticks, 0 = idle
//   cfg_valid  in   divisor update request
//   cfg_div    in   requested divisor N (fast_clk cycles per rx_tick)
//   cfg_frac   in   fractional divisor in 1/16 units (UART_BAUD_FRAC_EN only)
//   cfg_ready  out  controller can accept a configuration
//   cfg_err    out  one-cycle pulse: the accepted N was below 2 and was ignored
//   rx_tick    out  one-cycle oversample strobe
//   tx_tick    out  one-cycle bit strobe
//   busy       out  controller is not idle
//
// state | meaning
// IDLE  | ticks off; counters held at zero; a new divisor loads directly
// RUN   | ticks running on div_q
// PEND  | ticks running on the old div_q; the new divisor waits for the tx_tick
module uart_baud_ctrl #(
    parameter int DIV_W      = 16,
    parameter int OVERSAMPLE = 16,
    parameter int DEF_DIV    = 21
) (
    input  logic             fast_clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
`ifdef UART_BAUD_FRAC_EN
    input  logic [3:0]       cfg_frac,
`endif
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             rx_tick,
    output logic             tx_tick,
    output logic             busy
);
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEF_DIV);

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, cnt_adv;
    logic [OS_W-1:0]  os_q, os_d, os_adv;
    logic             err_q, err_d;
    logic             cfg_take, cfg_ok;
    logic [DIV_W-1:0] cnt_lim;

`ifdef UART_BAUD_FRAC_EN
    logic [3:0] frac_q, frac_d, frac_pend_q, frac_pend_d;
    logic [3:0] acc_q, acc_d, acc_adv;
    logic       ext_q, ext_d, ext_adv;
    logic [4:0] acc_sum;

    // ext_q stretches the current sample period by one cycle. N is at least 2,
    // so div_q-1+1 always fits in DIV_W bits.
    assign cnt_lim = div_q - DIV_W'(1) + DIV_W'(ext_q);
    assign acc_sum = {1'b0, acc_q} + {1'b0, frac_q};
`else
    assign cnt_lim = div_q - DIV_W'(1);
`endif

    assign cfg_ready = (state_q != PEND);
    assign busy      = (state_q != IDLE);
    assign cfg_err   = err_q;
    assign rx_tick   = (state_q != IDLE) && (cnt_q == cnt_lim);
    assign tx_tick   = rx_tick && (os_q == OS_LAST);

    assign cfg_take  = cfg_valid && cfg_ready;
    assign cfg_ok    = cfg_take && (cfg_div >= DIV_W'(2));

    // Counter advance used by both RUN and PEND when they keep counting.
    always_comb begin
        cnt_adv = cnt_q + DIV_W'(1);
        os_adv  = os_q;
`ifdef UART_BAUD_FRAC_EN
        acc_adv = acc_q;
        ext_adv = ext_q;
`endif
        if (rx_tick) begin
            cnt_adv = '0;
            os_adv  = (os_q == OS_LAST) ? '0 : os_q + OS_W'(1);
`ifdef UART_BAUD_FRAC_EN
            acc_adv = acc_sum[3:0];
            ext_adv = acc_sum[4];
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        pend_d  = pend_q;
        cnt_d   = cnt_adv;
        os_d    = os_adv;
        err_d   = cfg_take && !cfg_ok;
`ifdef UART_BAUD_FRAC_EN
        frac_d      = frac_q;
        frac_pend_d = frac_pend_q;
        acc_d       = acc_adv;
        ext_d       = ext_adv;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                os_d  = '0;
`ifdef UART_BAUD_FRAC_EN
                acc_d = '0;
                ext_d = 1'b0;
                if (cfg_ok) frac_d = cfg_frac;
`endif
                if (cfg_ok) div_d = cfg_div;
                if (en) state_d = RUN;
            end
            RUN: begin
                if (!en) begin
                    // The controller stops at this same edge, so the new
                    // divisor is safe to load straight away.
                    state_d = IDLE;
                    cnt_d   = '0;
                    os_d    = '0;
`ifdef UART_BAUD_FRAC_EN
                    acc_d = '0;
                    ext_d = 1'b0;
                    if (cfg_ok) frac_d = cfg_frac;
`endif
                    if (cfg_ok) div_d = cfg_div;
                end else if (cfg_ok) begin
                    state_d = PEND;
                    pend_d  = cfg_div;
`ifdef UART_BAUD_FRAC_EN
                    frac_pend_d = cfg_frac;
`endif
                end
            end
            PEND: begin
                if (!en || tx_tick) begin
                    state_d = en ? RUN : IDLE;
                    div_d   = pend_q;
                    cnt_d   = '0;
                    os_d    = '0;
`ifdef UART_BAUD_FRAC_EN
                    frac_d = frac_pend_q;
                    acc_d  = '0;
                    ext_d  = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= DEF_DIV_V;
            pend_q  <= '0;
            cnt_q   <= '0;
            os_q    <= '0;
            err_q   <= 1'b0;
`ifdef UART_BAUD_FRAC_EN
            frac_q      <= '0;
            frac_pend_q <= '0;
            acc_q       <= '0;
            ext_q       <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            os_q    <= os_d;
            err_q   <= err_d;
`ifdef UART_BAUD_FRAC_EN
            frac_q      <= frac_d;
            frac_pend_q <= frac_pend_d;
            acc_q       <= acc_d;
            ext_q       <= ext_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Testbench for uart_baud_ctrl. Expected tick times are queued when stimulus
// is applied. A monitor pops one entry for each rx_tick it sees.
module tb_uart_baud_ctrl;
    localparam int DIV_W = 16;

    logic             fast_clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
`ifdef UART_BAUD_FRAC_EN
    logic [3:0]       cfg_frac;
`endif
    logic             cfg_ready, cfg_err, rx_tick, tx_tick, busy;

    typedef struct {
        int cyc;
        bit tx;
    } tick_t;

    tick_t exp_q[$];
    tick_t mon_t;
    int    cyc = 0;
    int    n_checks = 0;
    int    n_errors = 0;

    uart_baud_ctrl #(.DIV_W(DIV_W), .OVERSAMPLE(16), .DEF_DIV(21)) dut (
        .fast_clk  (fast_clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
`ifdef UART_BAUD_FRAC_EN
        .cfg_frac  (cfg_frac),
`endif
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .rx_tick   (rx_tick),
        .tx_tick   (tx_tick),
        .busy      (busy)
    );

    always #5 fast_clk = ~fast_clk;
    always @(posedge fast_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Queue ticks k0..k1 of a stream whose tick 0 is at cycle 'first'.
    task automatic push_ticks(input int first, input int period, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            tick_t t;
            t.cyc = first + period * k;
            t.tx  = ((k % 16) == 15);
            exp_q.push_back(t);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge fast_clk);
    endtask

    always @(negedge fast_clk) begin
        if (rst_n === 1'b1) begin
            if (rx_tick) begin
                if (exp_q.size() == 0) begin
                    check_eq("rx_unexpected", rx_tick, 0);
                end else begin
                    mon_t = exp_q.pop_front();
                    check_eq("rx_cyc", cyc, mon_t.cyc);
                    check_eq("tx_flag", tx_tick, mon_t.tx);
                end
            end else if (tx_tick) begin
                check_eq("tx_without_rx", tx_tick, rx_tick);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e, t, e2, e3;
        rst_n     = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
`ifdef UART_BAUD_FRAC_EN
        cfg_frac  = '0;
`endif
        #3 rst_n = 1'b0;
        #1;
        check_eq("rst_rx", rx_tick, 0);
        check_eq("rst_tx", tx_tick, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", cfg_ready, 1);
        check_eq("rst_err", cfg_err, 0);
        repeat (3) @(negedge fast_clk);
        rst_n = 1'b1;

        // Default divisor: ticks every 21 cycles, tx on every 16th tick.
        @(negedge fast_clk);
        check_eq("idle_busy", busy, 0);
        en = 1'b1;
        e  = cyc + 1;
        push_ticks(e + 20, 21, 0, 31);
        t  = e + 20 + 21 * 31;

        // Load divisor 10 at os=5; it takes effect after the frame's tx_tick.
        wait_cyc(e + 441);
        check_eq("run_ready", cfg_ready, 1);
        check_eq("run_busy", busy, 1);
        cfg_valid = 1'b1;
        cfg_div   = 10;
        @(negedge fast_clk);
        cfg_valid = 1'b0;
        check_eq("pend_ready", cfg_ready, 0);
        check_eq("pend_busy", busy, 1);
        push_ticks(t + 10, 10, 0, 33);
        wait_cyc(t);
        check_eq("pend_ready_at_tx", cfg_ready, 0);
        @(negedge fast_clk);
        check_eq("ready_after_tx", cfg_ready, 1);

        // Divisor below 2: error pulse, no other effect.
        wait_cyc(t + 165);
        cfg_valid = 1'b1;
        cfg_div   = 1;
        @(negedge fast_clk);
        cfg_valid = 1'b0;
        check_eq("err_pulse", cfg_err, 1);
        check_eq("err_ready", cfg_ready, 1);
        @(negedge fast_clk);
        check_eq("err_clear", cfg_err, 0);
        check_eq("err_busy", busy, 1);

        // Load divisor 8 (deferred), then drop en before the tx_tick.
        wait_cyc(t + 335);
        cfg_valid = 1'b1;
        cfg_div   = 8;
        @(negedge fast_clk);
        cfg_valid = 1'b0;
        check_eq("pend2_ready", cfg_ready, 0);
        wait_cyc(t + 343);
        en = 1'b0;
        @(negedge fast_clk);
        check_eq("stop_busy", busy, 0);
        check_eq("stop_rx", rx_tick, 0);
        check_eq("stop_ready", cfg_ready, 1);
        wait_cyc(t + 360);
        check_eq("drain_stop", exp_q.size(), 0);
        en = 1'b1;
        e2 = cyc + 1;
        push_ticks(e2 + 7, 8, 0, 15);

        // Async reset between edges while a tick and cfg_err are both high.
        wait_cyc(e2 + 30);
        cfg_valid = 1'b1;
        cfg_div   = 0;
        @(negedge fast_clk);
        cfg_valid = 1'b0;
        #1;
        check_eq("pre_rst_err", cfg_err, 1);
        check_eq("pre_rst_rx", rx_tick, 1);
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        check_eq("arst_rx", rx_tick, 0);
        check_eq("arst_tx", tx_tick, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_err", cfg_err, 0);
        check_eq("arst_ready", cfg_ready, 1);
        exp_q.delete();
        @(negedge fast_clk);
        @(negedge fast_clk);
        rst_n = 1'b1;
        @(negedge fast_clk);
        en = 1'b1;
        e3 = cyc + 1;
        push_ticks(e3 + 20, 21, 0, 2);
        wait_cyc(e3 + 64);
        en = 1'b0;
        @(negedge fast_clk);
        check_eq("drain_rst", exp_q.size(), 0);

`ifdef UART_BAUD_FRAC_EN
        // Fractional divisor 21 + 12/16: 12 of every 16 periods are 22 cycles long.
        begin
            int tt, acc, ext, s;
            cfg_valid = 1'b1;
            cfg_div   = 21;
            cfg_frac  = 12;
            @(negedge fast_clk);
            cfg_valid = 1'b0;
            cfg_frac  = 0;
            en  = 1'b1;
            tt  = cyc;
            acc = 0;
            ext = 0;
            for (int k = 0; k < 32; k++) begin
                tick_t x;
                tt   += 21 + ext;
                x.cyc = tt;
                x.tx  = ((k % 16) == 15);
                exp_q.push_back(x);
                s   = acc + 12;
                ext = (s > 15) ? 1 : 0;
                acc = s % 16;
            end
            wait_cyc(tt + 2);
            en = 1'b0;
            @(negedge fast_clk);
            check_eq("drain_frac", exp_q.size(), 0);
        end
`endif

        check_eq("drain_end", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
